// File: rtl/restador_serial_nbit_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and reset state.
package restador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rs_state_t;

    localparam rs_state_t STATE_RESET = IDLE;

endpackage

// File: rtl/restador_serial_nbit_if.sv
// Start/busy/done handshake plus operand and flag buses of the serial subtractor.
interface restador_serial_nbit_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         Bout;
    logic         overflow;
    logic         zero;
    logic         negative;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, overflow, zero, negative
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, overflow, zero, negative
    );
endinterface

// File: rtl/restador_serial_nbit_1bit.sv
// Combinational full subtractor: d = a - b - bin, bout = borrow out.
module restador_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/restador_serial_nbit.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock behind a start/busy/done handshake.
module restador_serial_nbit
    import restador_pkg::*;
#(
    parameter int N = 4
) (
    input logic                  clk,
    input logic                  rst,
    restador_serial_nbit_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    rs_state_t    state_reg;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [N-1:0] res_reg;
    logic         br_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0] diff_reg;
    logic         bout_reg;
    logic         overflow_reg;
    logic         zero_reg;
    logic         negative_reg;

    logic         d_bit;
    logic         br_next;
    logic [N-1:0] res_next;

    // Single full-subtractor cell, fed from the operand LSBs each RUN cycle.
    restador_1bit u_bit (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_next)
    );

    assign res_next = {d_bit, res_reg[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= STATE_RESET;
            a_reg        <= '0;
            b_reg        <= '0;
            res_reg      <= '0;
            br_reg       <= 1'b0;
            cnt_reg      <= '0;
            diff_reg     <= '0;
            bout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
            negative_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.A;
                        b_reg     <= bus.B;
                        br_reg    <= bus.Bin;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= res_next;
                    br_reg  <= br_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Last bit: br_reg is the borrow into the MSB, br_next the borrow out.
                    if (cnt_reg == CW'(N - 1)) begin
                        diff_reg     <= res_next;
                        bout_reg     <= br_next;
                        overflow_reg <= br_next ^ br_reg;
                        zero_reg     <= (res_next == '0);
                        negative_reg <= res_next[N-1];
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= STATE_RESET;
                end
            endcase
        end
    end

    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = (state_reg == DONE);
    assign bus.Diff     = diff_reg;
    assign bus.Bout     = bout_reg;
    assign bus.overflow = overflow_reg;
    assign bus.zero     = zero_reg;
    assign bus.negative = negative_reg;
endmodule

// File: tb/tb_restador_serial_nbit.sv
// Scoreboard bench for restador_serial_nbit: arithmetic reference model, directed and random operations.
module tb_restador_serial_nbit;
    localparam int N = 4;
    localparam int M = 1 << N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    restador_serial_nbit_if #(.N(N)) bus ();

    restador_serial_nbit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
        logic         neg;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: plain integer arithmetic, unsigned and signed views of the operands.
    function automatic exp_t model(input int a, input int b, input int bin);
        exp_t e;
        int raw, sa, sb, sr, m;
        raw = a - b - bin;
        m   = ((raw % M) + M) % M;
        sa  = (a >= M / 2) ? a - M : a;
        sb  = (b >= M / 2) ? b - M : b;
        sr  = sa - sb - bin;
        e.diff = N'(m);
        e.bout = (raw < 0);
        e.ovf  = (sr < -(M / 2)) || (sr > (M / 2) - 1);
        e.zero = (m == 0);
        e.neg  = (m >= M / 2);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse, also checks pulse width, busy length, output stability.
    exp_t out_prev;
    exp_t out_now;
    logic done_prev  = 1'b0;
    logic rst_prev   = 1'b1;
    int   busy_run   = 0;

    always @(negedge clk) begin
        exp_t e;
        out_now = '{bus.Diff, bus.Bout, bus.overflow, bus.zero, bus.negative};
        if (rst) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                check("done_width", {31'd0, done_prev}, 32'd0);
                check("busy_cycles", busy_run, N);
                busy_run = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("diff", {28'd0, out_now.diff}, {28'd0, e.diff});
                    check("bout", {31'd0, out_now.bout}, {31'd0, e.bout});
                    check("overflow", {31'd0, out_now.ovf}, {31'd0, e.ovf});
                    check("zero", {31'd0, out_now.zero}, {31'd0, e.zero});
                    check("negative", {31'd0, out_now.neg}, {31'd0, e.neg});
                    $display("op done: Diff=%b Bout=%b ovf=%b zero=%b neg=%b", out_now.diff,
                             out_now.bout, out_now.ovf, out_now.zero, out_now.neg);
                end
            end else if (!rst_prev) begin
                check("outputs_stable", 32'(out_now), 32'(out_prev));
            end
        end
        out_prev  = out_now;
        done_prev = bus.done;
        rst_prev  = rst;
    end

    // One operation: optionally disturb A/B/Bin and pulse start during RUN cycles 1-3.
    task automatic issue(input int a, input int b, input int bin, input bit wiggle);
        int cycles;
        @(negedge clk);
        bus.A     = N'(a);
        bus.B     = N'(b);
        bus.Bin   = bin[0];
        bus.start = 1'b1;
        sb_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles = 0;
        while (cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) break;
            if (wiggle && cycles <= 3) begin
                bus.A     = N'($urandom);
                bus.B     = N'($urandom);
                bus.Bin   = 1'($urandom);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("done_latency", cycles, N);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_outputs", 32'({bus.Diff, bus.Bout, bus.overflow, bus.zero, bus.negative}), 32'd0);
        rst = 1'b0;

        issue(4'b0111, 4'b0011, 0, 0);
        issue(4'b0011, 4'b0111, 0, 0);
        issue(4'b1000, 4'b0001, 0, 0);
        issue(4'b0111, 4'b1111, 0, 0);
        issue(4'b0101, 4'b0101, 0, 0);
        issue(4'b0000, 4'b0000, 1, 0);
        issue(4'b0111, 4'b0011, 0, 1);

        // Reset in the middle of a second operation discards it entirely.
        @(negedge clk);
        bus.A = 4'b1010; bus.B = 4'b0011; bus.Bin = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrun_rst_done", {31'd0, bus.done}, 32'd0);
        check("midrun_rst_outputs", 32'({bus.Diff, bus.Bout, bus.overflow, bus.zero, bus.negative}), 32'd0);
        repeat (N + 3) @(posedge clk);

        // Back-to-back with start held high: acceptance every N+2 edges.
        @(negedge clk);
        bus.A = N'($urandom); bus.B = N'($urandom); bus.Bin = 1'($urandom);
        bus.start = 1'b1;
        sb_q.push_back(model(int'(bus.A), int'(bus.B), int'(bus.Bin)));
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            bus.A = N'($urandom); bus.B = N'($urandom); bus.Bin = 1'($urandom);
            sb_q.push_back(model(int'(bus.A), int'(bus.B), int'(bus.Bin)));
            repeat (N + 2) @(posedge clk);
        end
        #1;
        bus.start = 1'b0;
        repeat (N + 3) @(posedge clk);

        for (int i = 0; i < 30; i++) begin
            issue(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                  int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/restador_serial_nbit.md
Name: restador_serial_nbit

Overview:
Bit-serial N-bit subtractor computing Diff = A - B - Bin one bit per clock, LSB first. It is the inverse operation of the team's combinational ripple adder and uses the same flag semantics (Cout/overflow become Bout/overflow). It sits in the lab ALU datapath where area matters more than latency, behind a start/busy/done handshake. Operands are captured on start, so upstream logic may change A and B while the operation runs.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
A  in  N  minuend, two's complement or unsigned
B  in  N  subtrahend
Bin  in  1  borrow-in
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when results become valid
Diff  out  N  registered difference
Bout  out  1  registered final borrow (1 = unsigned A < B + Bin)
overflow  out  1  registered signed overflow
zero  out  1  registered, Diff == 0
negative  out  1  registered, Diff[N-1]

Behaviour:
- Reset: on a clk edge with rst=1, state goes to IDLE and all outputs and internal registers go to 0. rst has priority over every other input, including mid-RUN; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. On that edge, capture A and B into shift registers, Bin into the borrow register, and clear bit counter cnt to 0.
  - RUN: each edge processes bit cnt.
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~a0 & br) | (b0 & br)
    - Operand registers shift right; d shifts into the MSB of the result shift register.
    - cnt increments; br_prev holds the borrow into the current bit.
    - On the edge where cnt == N-1, go to DONE and load the outputs:
      - Diff = result shift register including the final d
      - Bout = br_next
      - overflow = br_next ^ br (borrow into MSB xor borrow out of MSB)
      - zero = (final Diff == 0)
      - negative = final Diff[N-1]
  - DONE -> IDLE unconditionally after one cycle.
- busy = (state == RUN); done = (state == DONE). Both are decoded from registered state, with no combinational path from any input.
- Latency: start sampled at edge E0. busy is high for exactly N cycles following E0. done is high in the cycle after edge E0+N. Next start is accepted at edge E0+N+2 at the earliest.
- start while RUN or DONE is ignored; no queuing.
- Outputs Diff, Bout, overflow, zero and negative change only at the RUN->DONE edge or on reset. They hold their values through IDLE until the next result.
- Counter width is $clog2(N), at least 1 bit. cnt never wraps in normal operation because RUN exits at N-1.
- Arithmetic is exact modulo 2^N. The + operator is not used for the data path; the counter may use it.

Decomposition:
- Shared package restador_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} rs_state_t
  - localparam STATE_RESET = IDLE
- One sub-module, restador_1bit: combinational full subtractor (a, b, bin -> d, bout). Instantiated once and reused serially each cycle.

Test Plan:
- N=4, A=0111, B=0011, Bin=0, start pulse -> busy for 4 cycles; done in 5th cycle after start; Diff=0100, Bout=0, overflow=0, zero=0, negative=0.
- A=0011, B=0111, Bin=0 -> Diff=1100, Bout=1, overflow=0, negative=1, zero=0.
- A=1000 (-8), B=0001, Bin=0 -> Diff=0111, Bout=0, overflow=1, negative=0; also A=0111, B=1111 -> Diff=1000, overflow=1, Bout=1.
- A=0101, B=0101, Bin=0 -> Diff=0000, zero=1, Bout=0; then A=0000, B=0000, Bin=1 -> Diff=1111, Bout=1, negative=1, overflow=0.
- Start A=0111, B=0011; change A/B and pulse start on cycles 1-3 of RUN -> ignored, result still 0100, exactly one done pulse; then assert rst for one cycle mid-RUN of a second operation -> next cycle busy=0, done=0, all outputs 0, no done pulse follows.
- Back-to-back: start held high continuously -> new operation begins at every E0+N+2 edge; each done pulse is exactly 1 cycle; outputs stable between done pulses.
